// File: rtl/fft_consts.sv
// fft_consts: shared constants and payload types for the FFT butterfly datapath.
//   N_LOG2   : log2 of FFT size (address width)
//   DATA_W   : sample component width, Q1.(DATA_W-1)
//   TW_W     : twiddle component width, Q1.(TW_W-1)
//   BFLY_LAT : issue-to-write latency of fft_butterfly_pipe in cycles
package fft_consts;

  localparam int unsigned N_LOG2   = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned TW_W     = 16;
  localparam int unsigned BFLY_LAT = 4;

  // Complex sample as stored in the ping-pong banks: {re, im}
  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // Per-butterfly bookkeeping that travels alongside the data
  typedef struct packed {
    logic [N_LOG2-1:0] addr_a;
    logic [N_LOG2-1:0] addr_b;
    logic [N_LOG2-1:0] stage;
    logic              wr_bank;
  } bfly_meta_t;

endpackage

// File: rtl/fft_cmul.sv
// fft_cmul: registered complex multiply P = B * W with round-half-up back to
// the B scale. Full-precision products, + 2^(W_W-2), >>> (W_W-1), kept at
// B_W+1 bits so that |B*W| slightly above full scale is still representable.
// Ports:
//   clk, rst        : clock, async active-high reset
//   b_re, b_im      : operand B, Q1.(B_W-1)
//   w_re, w_im      : twiddle W, Q1.(W_W-1)
//   p_re, p_im      : registered product, B_W+1 bits signed
module fft_cmul #(
  parameter int unsigned B_W = 16,
  parameter int unsigned W_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [B_W-1:0] b_re,
  input  logic signed [B_W-1:0] b_im,
  input  logic signed [W_W-1:0] w_re,
  input  logic signed [W_W-1:0] w_im,
  output logic signed [B_W:0]   p_re,
  output logic signed [B_W:0]   p_im
);

  localparam int unsigned PROD_W = B_W + W_W;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(1) << (W_W - 2);

  logic signed [PROD_W-1:0] rr, ii, ri, ir;
  logic signed [SUM_W-1:0]  sum_re, sum_im;
  logic signed [B_W:0]      p_re_c, p_im_c;

  // Cross products, complex combine and rounding
  always_comb begin
    rr     = PROD_W'(b_re) * PROD_W'(w_re);
    ii     = PROD_W'(b_im) * PROD_W'(w_im);
    ri     = PROD_W'(b_re) * PROD_W'(w_im);
    ir     = PROD_W'(b_im) * PROD_W'(w_re);
    sum_re = SUM_W'(rr) - SUM_W'(ii);
    sum_im = SUM_W'(ri) + SUM_W'(ir);
    p_re_c = (B_W+1)'((sum_re + RND) >>> (W_W - 1));
    p_im_c = (B_W+1)'((sum_im + RND) >>> (W_W - 1));
  end

  // Product register (pipeline stage P3)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_re <= '0;
      p_im <= '0;
    end else begin
      p_re <= p_re_c;
      p_im <= p_im_c;
    end
  end

endmodule

// File: rtl/fft_butterfly_pipe.sv
// fft_butterfly_pipe: 4-stage radix-2 DIT butterfly, A' = A + B*W, B' = A - B*W,
// one butterfly per cycle, writes to the opposite ping-pong bank 4 cycles
// after issue. No stall or backpressure.
// Optional macro FFT_BFLY_SCALE_EN: outputs are halved with round-half-up
// (1/N overall FFT gain); otherwise outputs saturate to DATA_W.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   in_valid, rd_addrA/B      : butterfly issue from the address generator
//   twiddle_idx, stage        : butterfly index within group, current stage
//   bank_sel                  : read bank; results go to ~bank_sel
//   agu_done                  : address generator finished (level)
//   rd_dataA/B                : operand data {re,im}, one cycle after issue
//   tw_addr                   : twiddle ROM address (combinational)
//   tw_data                   : twiddle {re,im}, one cycle after tw_addr
//   wr_en, wr_bank            : result write strobe and destination bank
//   wr_addrA/B, wr_dataA/B    : result addresses and data {re,im}
//   drained                   : no valid entry anywhere in the pipe
//   done_out                  : one-cycle pulse once the FFT is written back
//   hazard_err                : sticky flag, issue overlapped a different stage
module fft_butterfly_pipe #(
  parameter int unsigned N_LOG2 = fft_consts::N_LOG2,
  parameter int unsigned DATA_W = fft_consts::DATA_W,
  parameter int unsigned TW_W   = fft_consts::TW_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [N_LOG2-1:0]     rd_addrA,
  input  logic [N_LOG2-1:0]     rd_addrB,
  input  logic [N_LOG2-2:0]     twiddle_idx,
  input  logic [N_LOG2-1:0]     stage,
  input  logic                  bank_sel,
  input  logic                  agu_done,
  input  logic [2*DATA_W-1:0]   rd_dataA,
  input  logic [2*DATA_W-1:0]   rd_dataB,
  output logic [N_LOG2-2:0]     tw_addr,
  input  logic [2*TW_W-1:0]     tw_data,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [N_LOG2-1:0]     wr_addrA,
  output logic [N_LOG2-1:0]     wr_addrB,
  output logic [2*DATA_W-1:0]   wr_dataA,
  output logic [2*DATA_W-1:0]   wr_dataB,
  output logic                  drained,
  output logic                  done_out,
  output logic                  hazard_err
);

  localparam int unsigned LAT = fft_consts::BFLY_LAT;
  localparam int unsigned CW  = 2 * DATA_W;
  localparam int unsigned PW  = DATA_W + 1;
  localparam int unsigned SW  = DATA_W + 2;
  localparam logic [N_LOG2-1:0]     STAGE_MAX = N_LOG2'(N_LOG2 - 1);
  localparam logic signed [SW-1:0]  SAT_MAX   = SW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0]  SAT_MIN   = ~SAT_MAX;

  // v_q[0..2] are the P1..P3 valid bits; wr_en is the P4 valid bit
  logic [LAT-2:0]         v_q;
  fft_consts::bfly_meta_t meta_q [LAT];
  logic signed [DATA_W-1:0] a2_re, a2_im, b2_re, b2_im, a3_re, a3_im;
  logic signed [TW_W-1:0]   w2_re, w2_im;
  logic signed [PW-1:0]     p_re, p_im;
  logic signed [SW-1:0]     sum_a_re, sum_a_im, sum_b_re, sum_b_im;
  logic                     agu_q, pending_done;
  logic                     agu_rise_c, drained_next_c, hazard_c;

  // Final reduction of a DATA_W+2 bit sum back to DATA_W
  function automatic logic [DATA_W-1:0] reduce(input logic signed [SW-1:0] x);
`ifdef FFT_BFLY_SCALE_EN
    return DATA_W'((x + SW'(1)) >>> 1);
`else
    if (x > SAT_MAX)      return DATA_W'(SAT_MAX);
    else if (x < SAT_MIN) return DATA_W'(SAT_MIN);
    else                  return DATA_W'(x);
`endif
  endfunction

  // Twiddle ROM address: j scaled by 2^(N_LOG2-1-stage)
  always_comb begin
    tw_addr = '0;
    if (stage <= STAGE_MAX) tw_addr = twiddle_idx << (STAGE_MAX - stage);
  end

  // Output add/subtract feeding P4
  always_comb begin
    sum_a_re = SW'(a3_re) + SW'(p_re);
    sum_a_im = SW'(a3_im) + SW'(p_im);
    sum_b_re = SW'(a3_re) - SW'(p_re);
    sum_b_im = SW'(a3_im) - SW'(p_im);
  end

  // Stage-overlap check of a new issue against every valid entry
  always_comb begin
    hazard_c = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      if (v_q[i] && (meta_q[i].stage != stage)) hazard_c = 1'b1;
    end
    if (wr_en && (meta_q[LAT-1].stage != stage)) hazard_c = 1'b1;
    hazard_c = hazard_c & in_valid;
  end

  // Done tracking looks at next-cycle occupancy so the pulse lands right
  // after the final write rather than one cycle later
  always_comb begin
    agu_rise_c     = agu_done & ~agu_q;
    drained_next_c = ~(in_valid | (|v_q));
    drained        = ~((|v_q) | wr_en);
  end

  fft_cmul #(
    .B_W (DATA_W),
    .W_W (TW_W)
  ) u_cmul (
    .clk  (clk),
    .rst  (rst),
    .b_re (b2_re),
    .b_im (b2_im),
    .w_re (w2_re),
    .w_im (w2_im),
    .p_re (p_re),
    .p_im (p_im)
  );

  // Pipeline registers, result registers and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q          <= '0;
      for (int i = 0; i < LAT; i++) meta_q[i] <= '0;
      a2_re        <= '0;
      a2_im        <= '0;
      b2_re        <= '0;
      b2_im        <= '0;
      w2_re        <= '0;
      w2_im        <= '0;
      a3_re        <= '0;
      a3_im        <= '0;
      wr_en        <= 1'b0;
      wr_dataA     <= '0;
      wr_dataB     <= '0;
      hazard_err   <= 1'b0;
      agu_q        <= 1'b0;
      pending_done <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      // P1: issue bookkeeping
      v_q       <= {v_q[LAT-3:0], in_valid};
      meta_q[0] <= '{addr_a: rd_addrA, addr_b: rd_addrB, stage: stage,
                     wr_bank: ~bank_sel};
      // P2: operand and twiddle capture
      meta_q[1] <= meta_q[0];
      a2_re     <= rd_dataA[CW-1:DATA_W];
      a2_im     <= rd_dataA[DATA_W-1:0];
      b2_re     <= rd_dataB[CW-1:DATA_W];
      b2_im     <= rd_dataB[DATA_W-1:0];
      w2_re     <= tw_data[2*TW_W-1:TW_W];
      w2_im     <= tw_data[TW_W-1:0];
      // P3: product registered inside u_cmul, A delayed to match
      meta_q[2] <= meta_q[1];
      a3_re     <= a2_re;
      a3_im     <= a2_im;
      // P4: results only update on a valid butterfly so outputs hold otherwise
      wr_en     <= v_q[LAT-2];
      if (v_q[LAT-2]) begin
        meta_q[LAT-1] <= meta_q[2];
        wr_dataA      <= {reduce(sum_a_re), reduce(sum_a_im)};
        wr_dataB      <= {reduce(sum_b_re), reduce(sum_b_im)};
      end

      if (hazard_c) hazard_err <= 1'b1;

      agu_q <= agu_done;
      if ((pending_done | agu_rise_c) & drained_next_c) begin
        done_out     <= 1'b1;
        pending_done <= 1'b0;
      end else begin
        done_out <= 1'b0;
        if (agu_rise_c) pending_done <= 1'b1;
      end
    end
  end

  assign wr_bank  = meta_q[LAT-1].wr_bank;
  assign wr_addrA = meta_q[LAT-1].addr_a;
  assign wr_addrB = meta_q[LAT-1].addr_b;

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Self-checking bench for fft_butterfly_pipe (N_LOG2=4, DATA_W=TW_W=16).
// Expected write-backs are queued at issue time; a monitor pops and compares
// on every wr_en. Build with or without FFT_BFLY_SCALE_EN.
module tb_fft_butterfly_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  rd_addrA, rd_addrB, stage;
  logic [2:0]  twiddle_idx;
  logic        bank_sel, agu_done;
  logic [31:0] rd_dataA, rd_dataB, tw_data;
  logic [2:0]  tw_addr;
  logic        wr_en, wr_bank;
  logic [3:0]  wr_addrA, wr_addrB;
  logic [31:0] wr_dataA, wr_dataB;
  logic        drained, done_out, hazard_err;

  fft_butterfly_pipe #(.N_LOG2(4), .DATA_W(16), .TW_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rd_addrA(rd_addrA),
    .rd_addrB(rd_addrB), .twiddle_idx(twiddle_idx), .stage(stage),
    .bank_sel(bank_sel), .agu_done(agu_done), .rd_dataA(rd_dataA),
    .rd_dataB(rd_dataB), .tw_addr(tw_addr), .tw_data(tw_data),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addrA(wr_addrA),
    .wr_addrB(wr_addrB), .wr_dataA(wr_dataA), .wr_dataB(wr_dataB),
    .drained(drained), .done_out(done_out), .hazard_err(hazard_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr_a;
    logic [3:0]  addr_b;
    logic        bank;
    logic [31:0] da;
    logic [31:0] db;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          n_wr = 0;
  int          last_wr_cyc = 0;
  int          n_done = 0;
  int          done_cyc = 0;
  logic [31:0] nxt_a = '0, nxt_b = '0, nxt_w = '0;
  logic [31:0] wtab [4] = '{32'h7FFF_0000, 32'h5A82_A57E, 32'h0000_8000, 32'hA57E_A57E};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] red(input longint x);
    longint y;
`ifdef FFT_BFLY_SCALE_EN
    y = (x + 1) >>> 1;
`else
    y = (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
`endif
    return 16'(y);
  endfunction

  // Reference butterfly from integer arithmetic
  function automatic logic [31:0] bfly_model(input logic [31:0] a, b, w, input bit minus);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    wr = longint'($signed(w[31:16]));
    wi = longint'($signed(w[15:0]));
    pr = (br * wr - bi * wi + 16384) >>> 15;
    pi = (br * wi + bi * wr + 16384) >>> 15;
    if (minus) return {red(ar - pr), red(ai - pi)};
    else       return {red(ar + pr), red(ai + pi)};
  endfunction

  // One clock of stimulus; operand/twiddle data lag the issue by one cycle
  task automatic drive(input logic v, input logic [3:0] aa, ab, input logic [2:0] j,
                       input logic [3:0] stg, input logic bs,
                       input logic [31:0] da, db, w, ea, eb);
    exp_t e;
    @(negedge clk);
    rd_dataA = nxt_a; rd_dataB = nxt_b; tw_data = nxt_w;
    in_valid = v; rd_addrA = aa; rd_addrB = ab; twiddle_idx = j;
    stage = stg; bank_sel = bs;
    nxt_a = da; nxt_b = db; nxt_w = w;
    if (v) begin
      e.addr_a = aa; e.addr_b = ab; e.bank = ~bs;
      e.da = ea; e.db = eb; e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic issue_m(input logic [3:0] aa, ab, input logic [2:0] j,
                         input logic [3:0] stg, input logic bs,
                         input logic [31:0] da, db, w);
    drive(1'b1, aa, ab, j, stg, bs, da, db, w,
          bfly_model(da, db, w, 1'b0), bfly_model(da, db, w, 1'b1));
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 12 && !drained; i++) idle();
    if (!drained) chk(name, drained, 1);
  endtask

  // Monitor: compare each write-back against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (wr_en) begin
      n_wr++;
      last_wr_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_wr", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_bank", wr_bank, e.bank);
        chk("wr_addrA", wr_addrA, e.addr_a);
        chk("wr_addrB", wr_addrB, e.addr_b);
        chk("wr_dataA", wr_dataA, e.da);
        chk("wr_dataB", wr_dataB, e.db);
        chk("latency", cyc, e.cyc + 4);
      end
    end
    if (done_out) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  initial begin
    int base_wr, base_done, t0;
    logic [31:0] a, b;
    rst = 1'b1; in_valid = 1'b0; rd_addrA = '0; rd_addrB = '0;
    twiddle_idx = '0; stage = '0; bank_sel = 1'b0; agu_done = 1'b0;
    rd_dataA = '0; rd_dataB = '0; tw_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_drained", drained, 1);
    chk("rst_done_out", done_out, 0);
    chk("rst_hazard_err", hazard_err, 0);
    chk("rst_wr_dataA", wr_dataA, 0);
    chk("rst_wr_addrB", wr_addrB, 0);
    rst = 1'b0;

    // Twiddle address scaling
    drive(1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0, '0, '0, '0, '0, '0);
    #1 chk("tw_addr_s0_j0", tw_addr, 0);
    drive(1'b0, 4'd0, 4'd0, 3'd3, 4'd2, 1'b0, '0, '0, '0, '0, '0);
    #1 chk("tw_addr_s2_j3", tw_addr, 6);
    drive(1'b0, 4'd0, 4'd0, 3'd5, 4'd3, 1'b0, '0, '0, '0, '0, '0);
    #1 chk("tw_addr_s3_j5", tw_addr, 5);

    // Directed vectors, hand-computed results, back to back
`ifdef FFT_BFLY_SCALE_EN
    drive(1'b1, 4'd2, 4'd3, 3'd0, 4'd0, 1'b0, 32'h1000_0000, 32'h0800_0000,
          32'h7FFF_0000, 32'h0C00_0000, 32'h0400_0000);
    drive(1'b1, 4'd5, 4'd13, 3'd0, 4'd0, 1'b1, 32'h0000_0000, 32'h4000_0000,
          32'h0000_8000, 32'h0000_E000, 32'h0000_2000);
    drive(1'b1, 4'd7, 4'd15, 3'd0, 4'd0, 1'b0, 32'h7FFF_8000, 32'h7FFF_8000,
          32'h7FFF_0000, 32'h7FFF_8001, 32'h0001_0000);
`else
    drive(1'b1, 4'd2, 4'd3, 3'd0, 4'd0, 1'b0, 32'h1000_0000, 32'h0800_0000,
          32'h7FFF_0000, 32'h1800_0000, 32'h0800_0000);
    drive(1'b1, 4'd5, 4'd13, 3'd0, 4'd0, 1'b1, 32'h0000_0000, 32'h4000_0000,
          32'h0000_8000, 32'h0000_C000, 32'h0000_4000);
    drive(1'b1, 4'd7, 4'd15, 3'd0, 4'd0, 1'b0, 32'h7FFF_8000, 32'h7FFF_8000,
          32'h7FFF_0000, 32'h7FFF_8000, 32'h0001_FFFF);
`endif
    idle();
    chk("drained_in_flight", drained, 0);
    wait_drained("drain_directed");

    // Stream: 32 butterflies across stages 0..3, draining between stages
    base_wr = n_wr; base_done = n_done;
    for (int s = 0; s < 4; s++) begin
      wait_drained("drain_stage");
      for (int j = 0; j < 8; j++) begin
        int k;
        k = s * 8 + j;
        a = {16'(100 * k), 16'(-50 * k)};
        b = {16'(200 + 16 * k), 16'(30 * k)};
        issue_m(4'(j), 4'(j + 8), 3'(j), 4'(s), 1'(s % 2), a, b, wtab[k % 4]);
      end
    end
    idle();
    agu_done = 1'b1;
    repeat (8) idle();
    agu_done = 1'b0;
    chk("stream_writes", n_wr - base_wr, 32);
    chk("stream_hazard", hazard_err, 0);
    chk("stream_done_count", n_done - base_done, 1);
    chk("stream_done_cycle", done_cyc, last_wr_cyc + 1);
    chk("stream_sb_empty", sb.size(), 0);

    // agu_done rising on an empty pipe pulses done the next cycle
    repeat (2) idle();
    base_done = n_done;
    idle();
    agu_done = 1'b1;
    t0 = cyc;
    repeat (3) idle();
    agu_done = 1'b0;
    chk("empty_done_count", n_done - base_done, 1);
    chk("empty_done_cycle", done_cyc, t0 + 1);

    // Stage overlap sets a sticky hazard, butterflies still complete
    issue_m(4'd0, 4'd8, 3'd0, 4'd0, 1'b0, 32'h0100_0200, 32'h0300_0400, wtab[0]);
    issue_m(4'd1, 4'd9, 3'd1, 4'd1, 1'b0, 32'h0500_0600, 32'h0700_0800, wtab[1]);
    idle();
    chk("hazard_set", hazard_err, 1);
    repeat (8) idle();
    chk("hazard_sticky", hazard_err, 1);
    chk("hazard_sb_empty", sb.size(), 0);

    // Reset while the pipe is fully occupied discards everything in flight
    for (int i = 0; i < 6; i++)
      issue_m(4'(i), 4'(i + 8), 3'(i), 4'd2, 1'b1, {16'(64 * i), 16'h0010},
              32'h0040_0020, wtab[i % 4]);
    #2;
    rst = 1'b1;
    sb.delete();
    nxt_a = '0; nxt_b = '0; nxt_w = '0;
    base_wr = n_wr;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_drained", drained, 1);
    chk("midrst_hazard_err", hazard_err, 0);
    chk("midrst_wr_en", wr_en, 0);
    rst = 1'b0;
    repeat (8) idle();
    chk("post_rst_writes", n_wr - base_wr, 0);
    chk("post_rst_drained", drained, 1);
    chk("post_rst_hazard_err", hazard_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
